lif_neuron_array: RTL and testbench
===================================

# lif_neuron_array

Time-multiplexed array of N_CH leaky integrate-and-fire neurons that share one update datapath. Each neuron has a saturating membrane, a refractory period and an optional adaptive threshold. A `step` pulse advances every channel by one timestep, scanning the channels in index order, and ends with a one-cycle spike-vector strobe. The block is the multi-channel, parametrised successor to the single-neuron `tt_um_LIF_neuron` core; it sits between the input-current registers and the spike/IO logic of the top-level wrapper.

## Interface
- N_CH, 4: number of neuron channels (≥2).
- W, 8: membrane, current and threshold width.
- LEAK_SHIFT, 3: leak per timestep is mem >> LEAK_SHIFT.
- REFRAC, 2: refractory length in timesteps (0 = none).
- ADAPT_INC, 8: threshold-offset increment per spike.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- step  in  1  starts one timestep update; sampled only in IDLE.
- in_cur  in  N_CH*W  unsigned input current; slice k belongs to channel k. Must be held stable while busy.
- thr  in  W  base firing threshold, unsigned.
- adapt_en  in  1  enables the adaptive threshold offset.
- dbg_sel  in  clog2(N_CH)  selects the channel whose membrane appears on dbg_mem.
- busy  out  1  high while a timestep is in progress.
- spike_vld  out  1  one-cycle strobe: spike_vec is valid.
- spike_vec  out  N_CH  spikes of the completed timestep; bit k = channel k.
- dbg_mem  out  W  registered value of mem[dbg_sel].

## Operation
- Per-channel state:
  - mem[k] (W bits)
  - refrac[k] (clog2(REFRAC+1) bits)
  - offset[k] (W bits)
- FSM states:
  - IDLE: busy=0. On step=1, go to SCAN with idx=0.
  - SCAN: updates channel idx each cycle, then idx+1. After idx=N_CH-1, go to DONE.
  - DONE: spike_vld=1 for this cycle only, then go to IDLE.
- Channel update when refrac[k] > 0:
  - refrac -= 1; mem stays 0; no spike.
- Channel update when refrac[k] = 0:
  - leaked = mem - (mem >> LEAK_SHIFT).
  - sum = leaked + in_cur[k], computed in W+1 bits and saturated to 2^W-1.
  - eff = thr + offset, computed in W+1 bits with no saturation.
  - Spike if sum ≥ eff: mem=0, refrac=REFRAC, spike bit set.
  - Otherwise: mem = sum.
- Offset behaviour (applies on every channel update, including refractory updates):
  - adapt_en=1, spike: offset += ADAPT_INC, saturating at 2^W-1.
  - adapt_en=1, no spike: offset -= 1 if offset > 0.
  - adapt_en=0: eff uses offset=0, and offset is cleared.
- spike_vec: each bit is written during its channel's update and held until the next spike_vld. Bits are not cleared at step start; every bit is overwritten during the scan.
- step pulses arriving in SCAN or DONE are ignored; they are neither queued nor counted.

## Timing
- Reset (rst=0, asynchronous):
  - All mem, refrac and offset = 0.
  - FSM = IDLE; busy=0, spike_vld=0, spike_vec=0, dbg_mem=0.
- Let E0 be the edge at which step=1 is sampled in IDLE.
  - busy rises after E0.
  - Channel k is updated at edge E0+1+k.
  - spike_vld is high for exactly one cycle, between edges E0+N_CH and E0+N_CH+1.
  - busy falls after E0+N_CH+1; a new step can be sampled from E0+N_CH+1 onward.
  - Throughput: one timestep per N_CH+1 cycles.
- dbg_mem latency is 1 cycle from dbg_sel and from any mem change.
- Reset asserted mid-scan aborts the timestep: no spike_vld, and all state is zeroed.
- in_cur, thr and adapt_en are read at the edge that updates the channel; changes during a scan affect only channels not yet updated.

## Test plan
All scenarios use the defaults: N_CH=4, W=8, LEAK_SHIFT=3, REFRAC=2, ADAPT_INC=8.
- Reset: pulse rst low mid-idle → busy, spike_vld, spike_vec and dbg_mem are all 0; dbg_mem reads 0 on every dbg_sel.
- Integration: thr=100, ch0 in_cur=30, other channels 0, four steps → mem0 = 30, 57, 80, then spike; spike_vec = 0001 on step 4 only, and mem0=0 after it.
- Refractory: continue the integration scenario with in_cur=30 → steps 5 and 6 have no spike and mem0=0; step 7 gives mem0=30.
- Saturation: thr=255, ch1 in_cur=200 → step 1 mem1=200; step 2 sum 375 saturates to 255, so spike_vec[1]=1 and mem1=0.
- Adaptive threshold: adapt_en=1, thr=50, ch2 in_cur=60 → step 1 spikes (offset 8); steps 2 and 3 are refractory (offset 7, then 6); step 4 has sum 60 ≥ 56, so it spikes and offset becomes 14.
- Handshake and abort:
  - step at E0 and again at E0+2 → exactly one spike_vld, high between E0+4 and E0+5.
  - Repeat with rst low at E0+2 → no spike_vld, and all state is 0.

Source files
------------

// File: rtl/lif_neuron_array_if.sv
// Bus bundle for the LIF neuron array: step control,
// per-channel currents, spike strobe and debug readout.
interface lif_neuron_array_if #(
   parameter int N_CH = 4,
   parameter int W    = 8
);
   localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             step;
   logic [N_CH*W-1:0] in_cur;
   logic [W-1:0]     thr;
   logic             adapt_en;
   logic [SW-1:0]    dbg_sel;
   logic             busy;
   logic             spike_vld;
   logic [N_CH-1:0]  spike_vec;
   logic [W-1:0]     dbg_mem;

   modport master (
      output step, in_cur, thr, adapt_en, dbg_sel,
      input  busy, spike_vld, spike_vec, dbg_mem
   );

   modport slave (
      input  step, in_cur, thr, adapt_en, dbg_sel,
      output busy, spike_vld, spike_vec, dbg_mem
   );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array
// with one shared update datapath scanning channels in order.
module lif_neuron_array #(
   parameter int N_CH       = 4,
   parameter int W          = 8,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2,
   parameter int ADAPT_INC  = 8
) (
   input logic clk,
   input logic rst,
   lif_neuron_array_if.slave bus
);
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t state, state_nx;
   logic [IW-1:0] idx, idx_nx;

   logic [W-1:0]  mem    [N_CH];
   logic [RW-1:0] refrac [N_CH];
   logic [W-1:0]  offset [N_CH];
   logic [N_CH-1:0] spike_vec;
   logic [W-1:0]    dbg_mem;

   logic [W-1:0] cur, leaked, sum, off_use, off_nx;
   logic [W:0]   sum_w, eff, inc_w;
   logic         in_ref, fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      unique case (state)
         IDLE: begin
            if (bus.step) begin
               state_nx = SCAN;
               idx_nx   = '0;
            end
         end
         SCAN: begin
            if (idx == IW'(N_CH - 1))
               state_nx = DONE;
            else
               idx_nx = idx + 1'b1;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Shared datapath for the channel selected by idx
   always_comb begin
      cur     = bus.in_cur[int'(idx)*W +: W];
      in_ref  = (refrac[idx] != '0);
      leaked  = mem[idx] - (mem[idx] >> LEAK_SHIFT);
      sum_w   = {1'b0, leaked} + {1'b0, cur};
      sum     = sum_w[W] ? '1 : sum_w[W-1:0];
      off_use = bus.adapt_en ? offset[idx] : '0;
      eff     = {1'b0, bus.thr} + {1'b0, off_use};
      fire    = !in_ref && ({1'b0, sum} >= eff);
      inc_w   = {1'b0, offset[idx]} + (W+1)'(ADAPT_INC);
      off_nx  = offset[idx];
      if (!bus.adapt_en)
         off_nx = '0;
      else if (fire)
         off_nx = inc_w[W] ? '1 : inc_w[W-1:0];
      else if (offset[idx] != '0)
         off_nx = offset[idx] - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N_CH; k++) begin
            mem[k]    <= '0;
            refrac[k] <= '0;
            offset[k] <= '0;
         end
         spike_vec <= '0;
         dbg_mem   <= '0;
      end else begin
         dbg_mem <= mem[bus.dbg_sel];
         if (state == SCAN) begin
            offset[idx]    <= off_nx;
            spike_vec[idx] <= fire;
            if (in_ref) begin
               refrac[idx] <= refrac[idx] - 1'b1;
               mem[idx]    <= '0;
            end else if (fire) begin
               mem[idx]    <= '0;
               refrac[idx] <= RW'(REFRAC);
            end else begin
               mem[idx] <= sum;
            end
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.spike_vld = (state == DONE);
   assign bus.spike_vec = spike_vec;
   assign bus.dbg_mem   = dbg_mem;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: directed scenarios
// plus randomized timesteps against an arithmetic model.
module tb_lif_neuron_array;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int LS = 3;
   localparam int RF = 2;
   localparam int AI = 8;
   localparam int SW = 2;
   localparam int MX = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lif_neuron_array_if #(.N_CH(N), .W(W)) bus ();

   lif_neuron_array #(
      .N_CH(N), .W(W), .LEAK_SHIFT(LS),
      .REFRAC(RF), .ADAPT_INC(AI)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int total = 0;
   int bad   = 0;
   logic [N-1:0] exp_q[$];
   int m_mem[N];
   int m_ref[N];
   int m_off[N];

   task automatic chk(input string name, input int act,
                      input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         m_mem[k] = 0;
         m_ref[k] = 0;
         m_off[k] = 0;
      end
   endtask

   // One timestep of every neuron, straight from the rules
   task automatic model_step(output logic [N-1:0] sv);
      int cur, lk, s, e;
      bit f;
      sv = '0;
      for (int k = 0; k < N; k++) begin
         cur = int'(bus.in_cur[k*W +: W]);
         f = 0;
         if (m_ref[k] > 0) begin
            m_ref[k]--;
            m_mem[k] = 0;
         end else begin
            lk = m_mem[k] - m_mem[k] / (1 << LS);
            s  = lk + cur;
            if (s > MX) s = MX;
            e = int'(bus.thr) + (bus.adapt_en ? m_off[k] : 0);
            if (s >= e) begin
               f = 1;
               m_mem[k] = 0;
               m_ref[k] = RF;
            end else begin
               m_mem[k] = s;
            end
         end
         if (!bus.adapt_en)
            m_off[k] = 0;
         else if (f)
            m_off[k] = (m_off[k] + AI > MX) ? MX : m_off[k] + AI;
         else if (m_off[k] > 0)
            m_off[k]--;
         sv[k] = f;
      end
   endtask

   initial begin
      logic [N-1:0] e;
      forever begin
         @(negedge clk);
         if (bus.spike_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spike_vld: got strobe vec=%b want none",
                        bus.spike_vec);
            end else begin
               e = exp_q.pop_front();
               chk("spike_vec", int'(bus.spike_vec), int'(e));
            end
         end
      end
   end

   task automatic check_mems(input string tag);
      for (int k = 0; k < N; k++) begin
         bus.dbg_sel = SW'(k);
         @(negedge clk);
         chk($sformatf("%s_mem%0d", tag, k),
             int'(bus.dbg_mem), m_mem[k]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_vld", int'(bus.spike_vld), 0);
      chk("rst_vec", int'(bus.spike_vec), 0);
      chk("rst_dbg", int'(bus.dbg_mem), 0);
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      check_mems("rst");
   endtask

   task automatic do_step(input bit dbl, input bit abort);
      logic [N-1:0] sv;
      int n;
      bit seen;
      @(negedge clk);
      bus.step = 1'b1;
      if (!abort) begin
         model_step(sv);
         exp_q.push_back(sv);
      end
      @(negedge clk);
      bus.step = 1'b0;
      n = 1;
      chk("busy_rise", int'(bus.busy), 1);
      seen = 0;
      while (!seen && n < 12) begin
         @(negedge clk);
         n++;
         if (bus.spike_vld === 1'b1) seen = 1;
         if (dbl && n == 2) bus.step = 1'b1;
         if (dbl && n == 3) bus.step = 1'b0;
         if (abort && n == 2) rst = 1'b0;
         if (abort && n == 3) begin
            rst = 1'b1;
            model_clear();
         end
      end
      if (!abort) begin
         chk("vld_cycle", seen ? n : -1, N + 1);
         @(negedge clk);
         chk("busy_fall", int'(bus.busy), 0);
      end else begin
         chk("abort_no_vld", int'(seen), 0);
         chk("abort_vec", int'(bus.spike_vec), 0);
         chk("abort_busy", int'(bus.busy), 0);
      end
   endtask

   initial begin
      bus.step     = 1'b0;
      bus.in_cur   = '0;
      bus.thr      = '0;
      bus.adapt_en = 1'b0;
      bus.dbg_sel  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      do_reset();

      // Integration then refractory on channel 0
      bus.thr    = 8'd100;
      bus.in_cur = {8'd0, 8'd0, 8'd0, 8'd30};
      for (int s = 0; s < 7; s++) begin
         do_step(0, 0);
         check_mems("integ");
      end

      // Saturation on channel 1
      do_reset();
      bus.thr    = 8'd255;
      bus.in_cur = {8'd0, 8'd0, 8'd200, 8'd0};
      for (int s = 0; s < 2; s++) begin
         do_step(0, 0);
         check_mems("sat");
      end

      // Adaptive threshold on channel 2
      do_reset();
      bus.adapt_en = 1'b1;
      bus.thr      = 8'd50;
      bus.in_cur   = {8'd0, 8'd60, 8'd0, 8'd0};
      for (int s = 0; s < 5; s++) begin
         do_step(0, 0);
         check_mems("adapt");
      end

      // Ignored second step, then mid-scan abort
      bus.in_cur = {8'd40, 8'd10, 8'd70, 8'd90};
      do_step(1, 0);
      check_mems("dbl");
      do_step(0, 1);
      check_mems("abort");

      // Randomized timesteps
      for (int s = 0; s < 40; s++) begin
         for (int k = 0; k < N; k++)
            bus.in_cur[k*W +: W] = W'($urandom_range(0, 140));
         bus.thr      = W'($urandom_range(20, 255));
         bus.adapt_en = 1'($urandom_range(0, 1));
         do_step(1'($urandom_range(0, 1)), 0);
         if (s % 8 == 7) check_mems("rnd");
      end
      check_mems("final");

      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
